// File: rtl/mem_line_responder_pkg.sv
// Shared types and defaults for the memory-side line responder.
// Holds the responder FSM state encoding and the default line/address widths.
package mem_resp_pkg;

  localparam int DEF_LINE_W = 128;
  localparam int DEF_ADDR_W = 28;
  localparam int LAT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_line_responder_if.sv
// Cache <-> memory line-transfer bus.
// The cache drives it through the master modport; the responder uses the slave modport.
interface mem_line_responder_if
  import mem_resp_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_line_responder_line_ram.sv
// Single-port DEPTH x LINE_W line store: synchronous write, registered read.
// The array is deliberately unreset so its contents survive a responder reset.
module line_ram #(
  parameter int DEPTH  = 256,
  parameter int LINE_W = 128,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only updates on a read, so it holds the last line read.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side line responder: one 128-bit line read/write at a time, completed after
// LATENCY cycles with a one-cycle mem_ready pulse. MEM_RESP_ERR_EN adds the sticky mem_err checker.
module mem_line_responder
  import mem_resp_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int DEPTH   = 256,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 proc_reset_n,
  mem_line_responder_if.slave  bus
`ifdef MEM_RESP_ERR_EN
  ,
  output logic                 mem_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ram_we;
  logic              ram_re;

  // Request fields are captured once at accept; BUSY works only from the latched copies.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          state_d = BUSY;
          op_wr_d = bus.mem_write;
          idx_d   = bus.mem_addr[IDX_W-1:0];
          wdata_d = bus.mem_wdata;
          cnt_d   = LAT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RESP;
          ram_we  = op_wr_q;
          ram_re  = ~op_wr_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.mem_ready = (state_q == RESP);

  line_ram #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (proc_reset_n),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (bus.mem_rdata)
  );

`ifdef MEM_RESP_ERR_EN
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  // The full address is kept so aliasing changes in the upper bits are still flagged.
  always_comb begin
    addr_d = addr_q;
    err_d  = err_q;
    if (state_q == IDLE && (bus.mem_read || bus.mem_write)) begin
      addr_d = bus.mem_addr;
      if (bus.mem_read && bus.mem_write) begin
        err_d = 1'b1;
      end
    end
    if (state_q == BUSY && (bus.mem_read || bus.mem_write) &&
        ((bus.mem_write != op_wr_q) || (bus.mem_addr != addr_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  assign mem_err = err_q;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder with a scoreboard of expected read-data values.
// Also exercises mem_err when built with MEM_RESP_ERR_EN.
module tb_mem_line_responder;

  localparam int LAT = 8;

  logic clk = 1'b0;
  logic proc_reset_n;
  always #5 clk = ~clk;

  mem_line_responder_if #(.LINE_W(128), .ADDR_W(28)) bus ();

`ifdef MEM_RESP_ERR_EN
  logic mem_err;
`endif

  mem_line_responder #(
    .LATENCY (LAT),
    .DEPTH   (256),
    .LINE_W  (128),
    .ADDR_W  (28)
  ) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .bus          (bus)
`ifdef MEM_RESP_ERR_EN
    ,
    .mem_err      (mem_err)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic [127:0] model_mem [256];
  logic [127:0] exp_rdata;

  typedef struct {
    logic [127:0] data;
    string        tag;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every mem_ready pulse must match a queued transaction and carry the expected rdata.
  always @(negedge clk) begin
    if (bus.mem_ready === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_ready observed=pulse expected=no_pulse");
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %s cyc=%0d rdata=%h", e.tag, cyc, bus.mem_rdata);
        chk({e.tag, "_rdata"}, bus.mem_rdata, e.data);
      end
    end
  end

  task automatic run(input string tag, input logic rd, input logic wr,
                     input logic [27:0] addr, input logic [127:0] wd,
                     input int drop_at, input logic [27:0] addr2, output int rc);
    int acc;
    logic [7:0] idx;
    idx = addr[7:0];
    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wd;
    if (wr) model_mem[idx] = wd;
    else    exp_rdata = model_mem[idx];
    sb.push_back('{exp_rdata, tag});
    @(posedge clk);
    #1 acc = cyc;
    rc = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == drop_at) begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = addr2;
      end
      if (bus.mem_ready === 1'b1) begin
        rc = cyc;
        break;
      end
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    chk({tag, "_latency"}, 128'(rc - acc), 128'(LAT));
  endtask

  initial begin
    int rc1, rc2, rc_tmp;
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    proc_reset_n  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    exp_rdata     = '0;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = {32'(4*i+3), 32'(4*i+2), 32'(4*i+1), 32'(4*i)};
      dut.u_ram.mem[i] = model_mem[i];
    end
    repeat (3) @(negedge clk);
    chk("reset_ready", 128'(bus.mem_ready), 128'(0));
    chk("reset_rdata", bus.mem_rdata, '0);
`ifdef MEM_RESP_ERR_EN
    chk("reset_err", 128'(mem_err), 128'(0));
`endif
    proc_reset_n = 1'b1;

    run("rd5", 1'b1, 1'b0, 28'd5, '0, 0, 28'd0, rc_tmp);
    chk("rd5_const", bus.mem_rdata, 128'h00000017_00000016_00000015_00000014);

    run("wr3", 1'b0, 1'b1, 28'd3, a5, 0, 28'd0, rc_tmp);
    run("rd3", 1'b1, 1'b0, 28'd3, '0, 0, 28'd0, rc_tmp);
    chk("rd3_const", bus.mem_rdata, a5);
    run("rd259", 1'b1, 1'b0, 28'd259, '0, 0, 28'd0, rc_tmp);
    chk("rd259_alias", bus.mem_rdata, a5);

    run("rd2", 1'b1, 1'b0, 28'd2, '0, 0, 28'd0, rc1);
    run("wr7", 1'b0, 1'b1, 28'd7, {4{32'hCAFE_0007}}, 0, 28'd0, rc2);
    chk("b2b_spacing", 128'(rc2 - rc1), 128'(LAT + 2));
    run("rd2_again", 1'b1, 1'b0, 28'd2, '0, 0, 28'd0, rc_tmp);
    chk("rd2_unchanged", bus.mem_rdata, 128'h0000000B_0000000A_00000009_00000008);
    run("rd7", 1'b1, 1'b0, 28'd7, '0, 0, 28'd0, rc_tmp);

    run("rd6_drop", 1'b1, 1'b0, 28'd6, '0, 2, 28'd10, rc_tmp);
    chk("rd6_drop_const", bus.mem_rdata, 128'h0000001B_0000001A_00000019_00000018);
`ifdef MEM_RESP_ERR_EN
    chk("drop_err", 128'(mem_err), 128'(0));
`endif

    // Abort a write to line 9 with reset mid-BUSY; no pulse, no array update.
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'd9;
    bus.mem_wdata = {4{32'hDEAD_BEEF}};
    @(posedge clk);
    repeat (3) @(negedge clk);
    proc_reset_n = 1'b0;
    #1;
    chk("rst_mid_ready", 128'(bus.mem_ready), 128'(0));
    chk("rst_mid_rdata", bus.mem_rdata, '0);
    bus.mem_write = 1'b0;
    exp_rdata     = '0;
    repeat (LAT + 2) begin
      @(negedge clk);
    end
    chk("rst_hold_ready", 128'(bus.mem_ready), 128'(0));
    proc_reset_n = 1'b1;
    run("rd9", 1'b1, 1'b0, 28'd9, '0, 0, 28'd0, rc_tmp);
    chk("rd9_const", bus.mem_rdata, 128'h00000027_00000026_00000025_00000024);

    run("rw4", 1'b1, 1'b1, 28'd4, {4{32'h1234_5678}}, 0, 28'd0, rc_tmp);
    chk("rw4_rdata_held", bus.mem_rdata, 128'h00000027_00000026_00000025_00000024);
    run("rd4", 1'b1, 1'b0, 28'd4, '0, 0, 28'd0, rc_tmp);
    chk("rd4_const", bus.mem_rdata, {4{32'h1234_5678}});
`ifdef MEM_RESP_ERR_EN
    chk("rw_err_sticky", 128'(mem_err), 128'(1));
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
